// File: rtl/sseg_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   scan_state_e : two-state scan FSM encoding (guard / drive)
//   SSEG_BLANK   : active-low {g..a} pattern with every segment off
//   SSEG_DASH    : active-low {g..a} pattern with only segment g lit
//   SSEG_DECODE  : active-low {g..a} patterns for BCD digits 0-9
package sseg_scan_driver_pkg;

    typedef enum logic {
        StGuard,
        StDrive
    } scan_state_e;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;
    localparam logic [6:0] SSEG_DASH  = 7'h3F;

    localparam logic [6:0] SSEG_DECODE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Data/display bundle of the seven-segment scan driver.
//   bcd_in : four BCD digits, [0] rightmost
//   load   : one-cycle strobe capturing bcd_in
//   dp_in  : live, active-high decimal-point request per digit
//   an     : active-low anode enables
//   sseg   : active-low segments {dp,g,f,e,d,c,b,a}
// master = the side supplying digits, slave = the driver.
interface sseg_scan_driver_if;

    logic [3:0] bcd_in [3:0];
    logic       load;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [7:0] sseg;

    modport master (
        output bcd_in,
        output load,
        output dp_in,
        input  an,
        input  sseg
    );

    modport slave (
        input  bcd_in,
        input  load,
        input  dp_in,
        output an,
        output sseg
    );

endinterface

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to seven-segment decoder.
//   bcd_i : 4-bit code; 10-15 are invalid and shown as a dash
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module bcd_to_sseg
    import sseg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SSEG_DASH;
        if (bcd_i < 4'd10) begin
            seg_o = SSEG_DECODE[bcd_i];
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Each digit slot lasts DIGIT_PERIOD cycles; the first GUARD_CYCLES of a slot
// keep every anode off so the previous digit's segments cannot ghost.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : digit load, decimal points and registered anode/segment outputs
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int unsigned DIGIT_PERIOD = 65536,
    parameter int unsigned GUARD_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    sseg_scan_driver_if.slave  bus
);

    localparam int unsigned CntW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntLast   = cnt_t'(DIGIT_PERIOD - 1);
    localparam cnt_t GuardLast = cnt_t'(GUARD_CYCLES - 1);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES >= DIGIT_PERIOD) begin : g_param_check
        $error("sseg_scan_driver: need 1 <= GUARD_CYCLES < DIGIT_PERIOD");
    end

    scan_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  digits_q [3:0];
    logic [3:0]  digits_d [3:0];
    logic [3:0]  an_q, an_d;
    logic [7:0]  sseg_q, sseg_d;

    logic [6:0]  dec_seg;
    logic        blank;

    // Digit register: load wins in any state, independent of the scan.
    always_comb begin
        digits_d = digits_q;
        if (bus.load) begin
            digits_d = bus.bcd_in;
        end
    end

    // Scan FSM: guard for the first GUARD_CYCLES of a slot, drive for the rest.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_t'(1);
        idx_d   = idx_q;
        if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StGuard;
            idx_d   = idx_q + 2'd1;
        end else if (cnt_q == GuardLast) begin
            state_d = StDrive;
        end
    end

    bcd_to_sseg u_decode (
        .bcd_i (digits_q[idx_q]),
        .seg_o (dec_seg)
    );

    // Leading-zero blanking; only a literal 0 counts as zero, so dashes stay visible.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd3:    blank = (digits_q[3] == 4'd0);
            2'd2:    blank = (digits_q[3] == 4'd0) && (digits_q[2] == 4'd0);
            2'd1:    blank = (digits_q[3] == 4'd0) && (digits_q[2] == 4'd0) &&
                             (digits_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
    end

    // Output values registered one cycle behind the scan state.
    always_comb begin
        an_d   = 4'hF;
        sseg_d = 8'hFF;
        if (state_q == StDrive) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = {~bus.dp_in[idx_q], blank ? SSEG_BLANK : dec_seg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StGuard;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            digits_q <= '{default: 4'd0};
            an_q     <= 4'hF;
            sseg_q   <= 8'hFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            an_q     <= an_d;
            sseg_q   <= sseg_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.sseg = sseg_q;

endmodule
